// File: rtl/pe_rs_if.sv
// Stream bundle for the row-stationary PE: filter, ifmap, upstream psum and result
// channels, each with a valid/ready handshake.
interface pe_rs_if #(
   parameter int DATA_W = 16,
   parameter int PSUM_W = 32
);
   logic [DATA_W-1:0] flt_data;
   logic              flt_valid;
   logic              flt_ready;
   logic [DATA_W-1:0] ifm_data;
   logic              ifm_valid;
   logic              ifm_ready;
   logic [PSUM_W-1:0] psum_in;
   logic              psum_in_valid;
   logic              psum_in_ready;
   logic [PSUM_W-1:0] psum_out;
   logic              psum_out_valid;
   logic              psum_out_ready;

   modport slave (
      input  flt_data, flt_valid, ifm_data, ifm_valid, psum_in, psum_in_valid, psum_out_ready,
      output flt_ready, ifm_ready, psum_in_ready, psum_out, psum_out_valid
   );

   modport master (
      output flt_data, flt_valid, ifm_data, ifm_valid, psum_in, psum_in_valid, psum_out_ready,
      input  flt_ready, ifm_ready, psum_in_ready, psum_out, psum_out_valid
   );
endinterface

// File: rtl/pe_rs.sv
// Row-stationary PE: holds a filter row, slides it over a streamed ifmap row and
// accumulates k signed products per output onto an incoming partial sum.
module pe_rs #(
   parameter int DATA_W     = 16,
   parameter int PSUM_W     = 32,
   parameter int FILT_DEPTH = 8,
   parameter int SAT_EN     = 1,
   localparam int KW        = $clog2(FILT_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [KW-1:0] cfg_k,
   input  logic [15:0]   cfg_nout,
   input  logic          cfg_reload,
   pe_rs_if.slave        bus,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);
   localparam int AW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_FILL   = 3'd2;
   localparam logic [2:0] S_PSUM   = 3'd3;
   localparam logic [2:0] S_MAC    = 3'd4;
   localparam logic [2:0] S_OUT    = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [15:0]       nout_q, nout_d;
   logic [KW-1:0]     wcnt_q, wcnt_d;
   logic [KW-1:0]     win_cnt_q, win_cnt_d;
   logic [15:0]       out_cnt_q, out_cnt_d;
   logic [KW-1:0]     tap_q, tap_d;
   logic [PSUM_W-1:0] acc_q, acc_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] w_q [FILT_DEPTH];
   logic [DATA_W-1:0] w_d [FILT_DEPTH];
   logic [DATA_W-1:0] win_q [FILT_DEPTH];
   logic [DATA_W-1:0] win_d [FILT_DEPTH];
   logic [DATA_W-1:0] win_shift [FILT_DEPTH];

   // Window is a shift register: newest sample at the top slot, so the last k
   // samples always sit in slots FILT_DEPTH-k .. FILT_DEPTH-1, oldest first.
   genvar gi;
   generate
      for (gi = 0; gi < FILT_DEPTH; gi++) begin : g_win
         if (gi == FILT_DEPTH - 1) begin : g_top
            assign win_shift[gi] = bus.ifm_data;
         end else begin : g_mid
            assign win_shift[gi] = win_q[gi+1];
         end
      end
   endgenerate

   logic [AW-1:0]         w_idx, win_idx;
   logic [DATA_W-1:0]     w_sel, x_sel;
   logic signed [2*DATA_W-1:0] w_ext, x_ext, prod;
   logic [PSUM_W:0]       sum_wide;
   logic [PSUM_W-1:0]     mac_res;

   assign w_idx   = AW'(tap_q);
   assign win_idx = AW'(KW'(FILT_DEPTH) - k_q + tap_q);
   assign w_sel   = w_q[w_idx];
   assign x_sel   = win_q[win_idx];
   assign w_ext   = {{DATA_W{w_sel[DATA_W-1]}}, w_sel};
   assign x_ext   = {{DATA_W{x_sel[DATA_W-1]}}, x_sel};
   assign prod    = w_ext * x_ext;
   assign sum_wide = {acc_q[PSUM_W-1], acc_q}
                   + {{(PSUM_W + 1 - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

   // One guard bit makes overflow visible as a mismatch of the top two bits.
   always_comb begin
      mac_res = sum_wide[PSUM_W-1:0];
      if (SAT_EN != 0 && (sum_wide[PSUM_W] != sum_wide[PSUM_W-1])) begin
         mac_res = sum_wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                    : {1'b0, {(PSUM_W-1){1'b1}}};
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      nout_d    = nout_q;
      wcnt_d    = wcnt_q;
      win_cnt_d = win_cnt_q;
      out_cnt_d = out_cnt_q;
      tap_d     = tap_q;
      acc_d     = acc_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      w_d       = w_q;
      win_d     = win_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_k == '0 || cfg_k > KW'(FILT_DEPTH) || cfg_nout == 16'd0) begin
                  err_d = 1'b1;
               end else begin
                  k_d       = cfg_k;
                  nout_d    = cfg_nout;
                  wcnt_d    = '0;
                  win_cnt_d = '0;
                  out_cnt_d = '0;
                  state_d   = cfg_reload ? S_LOAD_W : S_FILL;
               end
            end
         end
         S_LOAD_W: begin
            if (bus.flt_valid) begin
               w_d[AW'(wcnt_q)] = bus.flt_data;
               wcnt_d = wcnt_q + KW'(1);
               if (wcnt_q + KW'(1) == k_q) state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (bus.ifm_valid) begin
               win_d = win_shift;
               if (win_cnt_q != k_q) win_cnt_d = win_cnt_q + KW'(1);
               // First output needs a full window; later ones slide by one sample.
               if (out_cnt_q != 16'd0 || win_cnt_q + KW'(1) == k_q) state_d = S_PSUM;
            end
         end
         S_PSUM: begin
            if (bus.psum_in_valid) begin
               acc_d   = bus.psum_in;
               tap_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = mac_res;
            tap_d = tap_q + KW'(1);
            if (tap_q == k_q - KW'(1)) state_d = S_OUT;
         end
         S_OUT: begin
            if (bus.psum_out_ready) begin
               out_cnt_d = out_cnt_q + 16'd1;
               if (out_cnt_q + 16'd1 == nout_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         nout_q    <= '0;
         wcnt_q    <= '0;
         win_cnt_q <= '0;
         out_cnt_q <= '0;
         tap_q     <= '0;
         acc_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < FILT_DEPTH; i++) begin
            w_q[i]   <= '0;
            win_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         nout_q    <= nout_d;
         wcnt_q    <= wcnt_d;
         win_cnt_q <= win_cnt_d;
         out_cnt_q <= out_cnt_d;
         tap_q     <= tap_d;
         acc_q     <= acc_d;
         done_q    <= done_d;
         err_q     <= err_d;
         w_q       <= w_d;
         win_q     <= win_d;
      end
   end

   assign bus.flt_ready      = (state_q == S_LOAD_W);
   assign bus.ifm_ready      = (state_q == S_FILL);
   assign bus.psum_in_ready  = (state_q == S_PSUM);
   assign bus.psum_out_valid = (state_q == S_OUT);
   assign bus.psum_out       = acc_q;
   assign busy               = (state_q != S_IDLE);
   assign done               = done_q;
   assign cfg_err            = err_q;
endmodule

// File: tb/tb_pe_rs.sv
// Scoreboard bench for pe_rs: a saturating and a wrapping instance share stimulus and
// are checked against a behavioural convolution model.
module tb_pe_rs;
   localparam int DW = 16;
   localparam int PW = 32;
   localparam int FD = 8;
   localparam int KW = 4;
   localparam longint MAXP = 64'sd2147483647;
   localparam longint MINP = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] cfg_k = '0;
   logic [15:0]   cfg_nout = '0;
   logic          cfg_reload = 1'b0;
   logic          busy_s, done_s, err_s, busy_w, done_w, err_w;

   pe_rs_if #(.DATA_W(DW), .PSUM_W(PW)) bs ();
   pe_rs_if #(.DATA_W(DW), .PSUM_W(PW)) bw ();

   assign bw.flt_data       = bs.flt_data;
   assign bw.flt_valid      = bs.flt_valid;
   assign bw.ifm_data       = bs.ifm_data;
   assign bw.ifm_valid      = bs.ifm_valid;
   assign bw.psum_in        = bs.psum_in;
   assign bw.psum_in_valid  = bs.psum_in_valid;
   assign bw.psum_out_ready = bs.psum_out_ready;

   pe_rs #(.DATA_W(DW), .PSUM_W(PW), .FILT_DEPTH(FD), .SAT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_nout(cfg_nout),
      .cfg_reload(cfg_reload), .bus(bs.slave), .busy(busy_s), .done(done_s), .cfg_err(err_s));

   pe_rs #(.DATA_W(DW), .PSUM_W(PW), .FILT_DEPTH(FD), .SAT_EN(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_nout(cfg_nout),
      .cfg_reload(cfg_reload), .bus(bw.slave), .busy(busy_w), .done(done_w), .cfg_err(err_w));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_ifm = 0;
   int flt_q[$], ifm_q[$], ps_q[$];
   int exp_s[$], exp_w[$];
   int ws_g[$], xs_g[$], ps_g[$];
   int w_model[FD];
   bit stall_en = 1'b0;
   int bp_mode = 0;
   bit lat_en = 1'b0;
   int lat_k = 0;
   bit flt_seen, err_seen;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic finish_now();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Stream feeders: handshake is judged at the negedge, data advances after the edge.
   initial begin : feed_flt
      bit hs;
      bs.flt_valid = 1'b0;
      bs.flt_data  = '0;
      forever begin
         @(negedge clk); hs = bs.flt_valid && bs.flt_ready;
         @(posedge clk); #1;
         if (hs && flt_q.size() > 0) void'(flt_q.pop_front());
         bs.flt_valid = (flt_q.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
         if (flt_q.size() > 0) bs.flt_data = DW'(flt_q[0]);
      end
   end

   initial begin : feed_ifm
      bit hs;
      bs.ifm_valid = 1'b0;
      bs.ifm_data  = '0;
      forever begin
         @(negedge clk); hs = bs.ifm_valid && bs.ifm_ready;
         @(posedge clk); #1;
         if (hs && ifm_q.size() > 0) void'(ifm_q.pop_front());
         bs.ifm_valid = (ifm_q.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
         if (ifm_q.size() > 0) bs.ifm_data = DW'(ifm_q[0]);
      end
   end

   initial begin : feed_psum
      bit hs;
      bs.psum_in_valid = 1'b0;
      bs.psum_in       = '0;
      forever begin
         @(negedge clk); hs = bs.psum_in_valid && bs.psum_in_ready;
         @(posedge clk); #1;
         if (hs && ps_q.size() > 0) void'(ps_q.pop_front());
         bs.psum_in_valid = (ps_q.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
         if (ps_q.size() > 0) bs.psum_in = PW'(ps_q[0]);
      end
   end

   initial begin : drv_rdy
      int low;
      low = 0;
      bs.psum_out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bp_mode == 0) bs.psum_out_ready = 1'b1;
         else if (bp_mode == 1) bs.psum_out_ready = ($urandom_range(0, 2) != 0);
         else if (bs.psum_out_valid && low < 5) begin
            bs.psum_out_ready = 1'b0;
            low++;
         end else begin
            bs.psum_out_ready = 1'b1;
            if (!bs.psum_out_valid) low = 0;
         end
      end
   end

   initial begin : mon
      bit pstall, pvalid;
      logic [31:0] pdata;
      int es, ew;
      pstall = 1'b0; pvalid = 1'b0; pdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pstall = 1'b0; pvalid = 1'b0;
            continue;
         end
         if (bs.flt_ready) flt_seen = 1'b1;
         if (err_s) err_seen = 1'b1;
         if (bs.ifm_valid && bs.ifm_ready) last_ifm = cyc;
         if (pstall) begin
            chk("hold_valid", 32'(bs.psum_out_valid), 32'd1);
            chk("hold_data", bs.psum_out, pdata);
         end
         if (bs.psum_out_valid) begin
            chk("out_other_ready", 32'({bs.flt_ready, bs.ifm_ready, bs.psum_in_ready}), 32'd0);
            chk("wrap_valid", 32'(bw.psum_out_valid), 32'd1);
            if (lat_en && !pvalid) chk("latency", 32'(cyc - last_ifm), 32'(lat_k + 2));
            if (bs.psum_out_ready) begin
               if (exp_s.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_output actual=%0h required=none", bs.psum_out);
               end else begin
                  es = exp_s.pop_front();
                  ew = exp_w.pop_front();
                  $display("out psum_sat=%08h exp=%08h psum_wrap=%08h exp=%08h",
                           bs.psum_out, es, bw.psum_out, ew);
                  chk("psum_sat", bs.psum_out, es);
                  chk("psum_wrap", bw.psum_out, ew);
               end
            end
         end
         pstall = bs.psum_out_valid && !bs.psum_out_ready;
         pvalid = bs.psum_out_valid;
         pdata  = bs.psum_out;
      end
   end

   // Reference: direct 1-D correlation with per-step clamp or 32-bit wrap.
   task automatic model(input int k, input int nout);
      longint as, aw, p;
      for (int j = 0; j < nout; j++) begin
         as = ps_g[j];
         aw = ps_g[j];
         for (int i = 0; i < k; i++) begin
            p  = longint'(w_model[i]) * longint'(xs_g[j+i]);
            as = as + p;
            if (as > MAXP) as = MAXP;
            if (as < MINP) as = MINP;
            aw = longint'(int'(aw + p));
         end
         exp_s.push_back(int'(as));
         exp_w.push_back(int'(aw));
      end
   endtask

   task automatic pulse_start(input int k, input int nout, input bit reload);
      @(posedge clk); #1;
      start = 1'b1; cfg_k = KW'(k); cfg_nout = 16'(nout); cfg_reload = reload;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_queues(input int k, input bit reload);
      if (reload) for (int i = 0; i < k; i++) begin
         w_model[i] = ws_g[i];
         flt_q.push_back(ws_g[i]);
      end
      foreach (xs_g[i]) ifm_q.push_back(xs_g[i]);
      foreach (ps_g[i]) ps_q.push_back(ps_g[i]);
   endtask

   task automatic run(input int k, input int nout, input bit reload, input bit poke);
      int n;
      load_queues(k, reload);
      model(k, nout);
      flt_seen = 1'b0;
      err_seen = 1'b0;
      pulse_start(k, nout, reload);
      if (poke) begin
         repeat (2) @(posedge clk);
         pulse_start(0, 0, 1'b1);
         pulse_start(2, 1, 1'b1);
      end
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!done_s && n < 4000);
      if (!done_s) begin
         checks++; errors++;
         $display("FAIL run_timeout actual=no_done required=done");
         finish_now();
      end
      chk("done_busy", 32'(busy_s), 32'd0);
      chk("done_wrap", 32'(done_w), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(done_s), 32'd0);
      chk("sb_empty", 32'(exp_s.size()), 32'd0);
      chk("ifm_consumed", 32'(ifm_q.size()), 32'd0);
      chk("psum_consumed", 32'(ps_q.size()), 32'd0);
      chk("no_cfg_err", 32'(err_seen), 32'd0);
      if (!reload) chk("flt_idle", 32'(flt_seen), 32'd0);
   endtask

   task automatic reject(input int k, input int nout);
      pulse_start(k, nout, 1'b1);
      @(negedge clk);
      chk("rej_err", 32'(err_s), 32'd1);
      chk("rej_busy", 32'(busy_s), 32'd0);
      @(negedge clk);
      chk("rej_err_pulse", 32'(err_s), 32'd0);
      chk("rej_busy_after", 32'(busy_s), 32'd0);
   endtask

   task automatic fill_basic();
      ws_g.delete(); xs_g.delete(); ps_g.delete();
      for (int i = 1; i <= 3; i++) ws_g.push_back(i);
      for (int i = 1; i <= 5; i++) xs_g.push_back(i);
      ps_g.push_back(0); ps_g.push_back(10); ps_g.push_back(100);
   endtask

   task automatic fill_rand(input int k, input int nout);
      ws_g.delete(); xs_g.delete(); ps_g.delete();
      for (int i = 0; i < k; i++) ws_g.push_back(int'(shortint'($urandom)));
      for (int i = 0; i < nout + k - 1; i++) xs_g.push_back(int'(shortint'($urandom)));
      for (int i = 0; i < nout; i++) ps_g.push_back(int'($urandom));
   endtask

   initial begin : main
      int k, nout, n;
      bit rl;
      for (int i = 0; i < FD; i++) w_model[i] = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'({busy_s, done_s, err_s, bs.psum_out_valid, bs.flt_ready,
                             bs.ifm_ready, bs.psum_in_ready}), 32'd0);
      chk("reset_psum", bs.psum_out, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outs", 32'({busy_s, done_s, err_s, bs.psum_out_valid, bw.psum_out_valid}), 32'd0);

      // Basic run, then weight reuse with starts poked while busy.
      lat_en = 1'b1; lat_k = 3;
      fill_basic();
      run(3, 3, 1'b1, 1'b0);
      fill_basic();
      run(3, 3, 1'b0, 1'b1);
      lat_en = 1'b0;

      // Saturation at both limits versus wrap.
      ws_g.delete(); xs_g.delete(); ps_g.delete();
      ws_g.push_back(32767);
      xs_g.push_back(32767); xs_g.push_back(-32768);
      ps_g.push_back(32'h7FFFFFF0); ps_g.push_back(32'h80000010);
      run(1, 2, 1'b1, 1'b0);

      reject(0, 3);
      reject(3, 0);
      reject(9, 1);

      // Backpressure: ready held low five cycles on every output.
      bp_mode = 2;
      fill_rand(2, 3);
      run(2, 3, 1'b1, 1'b0);

      stall_en = 1'b1;
      for (int r = 0; r < 10; r++) begin
         k = $urandom_range(1, FD);
         nout = $urandom_range(1, 6);
         rl = ($urandom_range(0, 2) != 0);
         bp_mode = $urandom_range(1, 2);
         fill_rand(k, nout);
         run(k, nout, rl, 1'b0);
      end

      // Reset during MAC, then a reuse run must see all-zero weights.
      stall_en = 1'b0; bp_mode = 0;
      fill_rand(3, 1);
      load_queues(3, 1'b1);
      pulse_start(3, 1, 1'b1);
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(bs.psum_in_valid && bs.psum_in_ready) && n < 200);
      chk("reach_psum", 32'(bs.psum_in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", 32'({busy_s, done_s, err_s, bs.psum_out_valid, bs.flt_ready,
                                 bs.ifm_ready, bs.psum_in_ready}), 32'd0);
      chk("rst_async_psum", bs.psum_out, 32'd0);
      flt_q.delete(); ifm_q.delete(); ps_q.delete();
      exp_s.delete(); exp_w.delete();
      for (int i = 0; i < FD; i++) w_model[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      fill_rand(3, 2);
      run(3, 2, 1'b0, 1'b0);

      finish_now();
   end
endmodule
